// File: rtl/isp_pkg.sv
// isp_lite shared package: BT.601 colour-space-conversion constants.
// Coefficients are signed Q0.8 (9-bit); CSC_RND is added before the >>CSC_FRAC
// so the shift yields the floor of (sum + 0.5), i.e. round-half-up.
package isp_pkg;

  localparam int CSC_RND  = 128;
  localparam int CSC_FRAC = 8;

  // One output channel's weights for R, G and B.
  typedef struct packed {
    logic signed [8:0] kr;
    logic signed [8:0] kg;
    logic signed [8:0] kb;
  } csc_coef_t;

  // Per-pixel processing mode carried down the pipeline with the data.
  typedef enum logic {
    CSC_MODE_CONVERT = 1'b0,
    CSC_MODE_BYPASS  = 1'b1
  } csc_mode_t;

  // Full-range BT.601.
  localparam csc_coef_t CSC_Y_FULL   = '{kr:  9'sd77,  kg:  9'sd150, kb:  9'sd29};
  localparam csc_coef_t CSC_U_FULL   = '{kr: -9'sd43,  kg: -9'sd85,  kb:  9'sd128};
  localparam csc_coef_t CSC_V_FULL   = '{kr:  9'sd128, kg: -9'sd107, kb: -9'sd21};

  // Studio-swing BT.601.
  localparam csc_coef_t CSC_Y_STUDIO = '{kr:  9'sd66,  kg:  9'sd129, kb:  9'sd25};
  localparam csc_coef_t CSC_U_STUDIO = '{kr: -9'sd38,  kg: -9'sd74,  kb:  9'sd112};
  localparam csc_coef_t CSC_V_STUDIO = '{kr:  9'sd112, kg: -9'sd94,  kb: -9'sd18};

  // Scale an 8-bit-referenced level up to a BITS-wide component.
  function automatic int csc_scale(input int level, input int bits);
    return level << (bits - 8);
  endfunction

endpackage

// File: rtl/isp_csc_chan.sv
// isp_csc_chan: one output channel of the colour-space converter.
// Stage 1 registers three signed products, stage 2 their rounded sum, stage 3
// the shifted/offset/clamped result (or the pass-through component in bypass).
// href_s2/mode_s2 come from the top's shared delay lines, aligned with stage 2.
module isp_csc_chan
  import isp_pkg::*;
#(
  parameter int        BITS    = 8,
  parameter csc_coef_t COEF    = '0,
  parameter int        OFFSET  = 0,
  parameter int        MIN_VAL = 0,
  parameter int        MAX_VAL = 255
) (
  input  logic            pclk,
  input  logic            rst_n,
  input  logic [BITS-1:0] r,
  input  logic [BITS-1:0] g,
  input  logic [BITS-1:0] b,
  input  logic [BITS-1:0] pass,
  input  logic            href_s2,
  input  csc_mode_t       mode_s2,
  output logic [BITS-1:0] dout
);

  localparam int PW = BITS + 10;  // product width
  localparam int SW = BITS + 11;  // sum width

  localparam logic signed [PW-1:0] KR = PW'($signed(COEF.kr));
  localparam logic signed [PW-1:0] KG = PW'($signed(COEF.kg));
  localparam logic signed [PW-1:0] KB = PW'($signed(COEF.kb));

  logic signed [PW-1:0] prod_r, prod_g, prod_b;
  logic [BITS-1:0]      pass_s1, pass_s2;
  logic signed [SW-1:0] sum_s2;
  logic signed [SW-1:0] scaled;
  logic signed [SW-1:0] offset_val;
  logic [BITS-1:0]      clamped;

  // Stage 1: unsigned components widened with a zero sign bit, times signed coefficients.
  // NOTE: every pipeline register is reset so nothing stale leaks out after rst_n;
  // sequential state uses <= so all stages update from pre-edge values.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      prod_r  <= '0;
      prod_g  <= '0;
      prod_b  <= '0;
      pass_s1 <= '0;
    end else begin
      prod_r  <= $signed(PW'({1'b0, r})) * KR;
      prod_g  <= $signed(PW'({1'b0, g})) * KG;
      prod_b  <= $signed(PW'({1'b0, b})) * KB;
      pass_s1 <= pass;
    end
  end

  // Stage 2: sign-extended sum plus rounding constant.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      sum_s2  <= '0;
      pass_s2 <= '0;
    end else begin
      sum_s2  <= SW'(prod_r) + SW'(prod_g) + SW'(prod_b) + SW'(CSC_RND);
      pass_s2 <= pass_s1;
    end
  end

  // Stage 3 datapath: floor shift, channel offset, clamp to the legal range.
  // NOTE: clamped is assigned on every path so no latch is inferred.
  always_comb begin
    scaled     = sum_s2 >>> CSC_FRAC;
    offset_val = scaled + SW'(OFFSET);
    clamped    = offset_val[BITS-1:0];
    if (offset_val < SW'(MIN_VAL)) begin
      clamped = BITS'(MIN_VAL);
    end else if (offset_val > SW'(MAX_VAL)) begin
      clamped = BITS'(MAX_VAL);
    end
  end

  // Stage 3 register: blank outside href, else converted or pass-through value.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
    end else if (!href_s2) begin
      dout <= '0;
    end else if (mode_s2 == CSC_MODE_BYPASS) begin
      dout <= pass_s2;
    end else begin
      dout <= clamped;
    end
  end

endmodule

// File: rtl/isp_csc.sv
// isp_csc: BT.601 RGB -> YUV444 converter, fixed 3-cycle latency.
// Holds the href/vsync delay lines, the vsync rise detector and the
// frame-latched bypass shadow; three isp_csc_chan instances do the math.
// Build option: define ISP_CSC_STUDIO_RANGE_EN for studio-swing coefficients,
// offsets and clamp limits; bypass behaviour is identical in both builds.
module isp_csc
  import isp_pkg::*;
#(
  parameter int BITS   = 8,
  parameter int WIDTH  = 1280,
  parameter int HEIGHT = 960
) (
  input  logic            pclk,
  input  logic            rst_n,
  input  logic            in_href,
  input  logic            in_vsync,
  input  logic [BITS-1:0] in_r,
  input  logic [BITS-1:0] in_g,
  input  logic [BITS-1:0] in_b,
  input  logic            bypass,
  output logic            out_href,
  output logic            out_vsync,
  output logic [BITS-1:0] out_y,
  output logic [BITS-1:0] out_u,
  output logic [BITS-1:0] out_v
);

  if (BITS < 8 || WIDTH < 1 || HEIGHT < 1) begin : g_param_check
    $error("isp_csc: BITS must be >= 8 and WIDTH/HEIGHT positive");
  end

  localparam int C_OFF = 1 << (BITS - 1);

`ifdef ISP_CSC_STUDIO_RANGE_EN
  localparam csc_coef_t Y_COEF = CSC_Y_STUDIO;
  localparam csc_coef_t U_COEF = CSC_U_STUDIO;
  localparam csc_coef_t V_COEF = CSC_V_STUDIO;
  localparam int        Y_OFF  = csc_scale(16, BITS);
  localparam int        Y_MIN  = csc_scale(16, BITS);
  localparam int        Y_MAX  = csc_scale(235, BITS);
  localparam int        C_MIN  = csc_scale(16, BITS);
  localparam int        C_MAX  = csc_scale(240, BITS);
`else
  localparam csc_coef_t Y_COEF = CSC_Y_FULL;
  localparam csc_coef_t U_COEF = CSC_U_FULL;
  localparam csc_coef_t V_COEF = CSC_V_FULL;
  localparam int        Y_OFF  = 0;
  localparam int        Y_MIN  = 0;
  localparam int        Y_MAX  = (1 << BITS) - 1;
  localparam int        C_MIN  = 0;
  localparam int        C_MAX  = (1 << BITS) - 1;
`endif

  logic      href_s1, href_s2, href_s3;
  logic      vsync_s1, vsync_s2, vsync_s3;
  logic      vsync_rise;
  csc_mode_t bypass_q;
  csc_mode_t mode_in, mode_s1, mode_s2;

  // A pixel arriving on the vsync rise already uses the newly latched mode.
  assign vsync_rise = in_vsync & ~vsync_s1;
  assign mode_in    = vsync_rise ? csc_mode_t'(bypass) : bypass_q;

  // Timing delay lines, bypass shadow and per-pixel mode pipeline.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      href_s1  <= 1'b0;
      href_s2  <= 1'b0;
      href_s3  <= 1'b0;
      vsync_s1 <= 1'b0;
      vsync_s2 <= 1'b0;
      vsync_s3 <= 1'b0;
      bypass_q <= CSC_MODE_CONVERT;
      mode_s1  <= CSC_MODE_CONVERT;
      mode_s2  <= CSC_MODE_CONVERT;
    end else begin
      href_s1  <= in_href;
      href_s2  <= href_s1;
      href_s3  <= href_s2;
      vsync_s1 <= in_vsync;
      vsync_s2 <= vsync_s1;
      vsync_s3 <= vsync_s2;
      if (vsync_rise) begin
        bypass_q <= csc_mode_t'(bypass);
      end
      mode_s1  <= mode_in;
      mode_s2  <= mode_s1;
    end
  end

  assign out_href  = href_s3;
  assign out_vsync = vsync_s3;

  isp_csc_chan #(
    .BITS(BITS), .COEF(Y_COEF), .OFFSET(Y_OFF), .MIN_VAL(Y_MIN), .MAX_VAL(Y_MAX)
  ) u_chan_y (
    .pclk(pclk), .rst_n(rst_n), .r(in_r), .g(in_g), .b(in_b), .pass(in_r),
    .href_s2(href_s2), .mode_s2(mode_s2), .dout(out_y)
  );

  isp_csc_chan #(
    .BITS(BITS), .COEF(U_COEF), .OFFSET(C_OFF), .MIN_VAL(C_MIN), .MAX_VAL(C_MAX)
  ) u_chan_u (
    .pclk(pclk), .rst_n(rst_n), .r(in_r), .g(in_g), .b(in_b), .pass(in_g),
    .href_s2(href_s2), .mode_s2(mode_s2), .dout(out_u)
  );

  isp_csc_chan #(
    .BITS(BITS), .COEF(V_COEF), .OFFSET(C_OFF), .MIN_VAL(C_MIN), .MAX_VAL(C_MAX)
  ) u_chan_v (
    .pclk(pclk), .rst_n(rst_n), .r(in_r), .g(in_g), .b(in_b), .pass(in_b),
    .href_s2(href_s2), .mode_s2(mode_s2), .dout(out_v)
  );

endmodule
